// File: rtl/ps2_tx_core.sv
// -----------------------------------------------------------------------------
// ps2_tx_core
//
// Host-to-device PS/2 transmitter. Runs the full host send sequence:
// clock inhibit, request-to-send (data low, clock released), eight data
// bits LSB first, odd parity and stop, all clocked by the device on
// ps2_clk falling edges, then samples the device acknowledge bit.
// Lines are open-drain: the *_oe_o outputs are active-high pull-low enables.
//
// Optional build macro:
//   PS2_TX_GLITCH_FILTER_EN - adds a 4-sample stability filter after the
//                             synchronizers on both PS/2 lines.
//
// Parameters:
//   INHIBIT_CYCLES  clk_i cycles the clock line is held low before RTS (>= 2)
//   TIMEOUT_CYCLES  max clk_i cycles between device clock falls / idle wait
//   CNT_WIDTH       width of the shared cycle counter
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous reset, active-high
//   ps2_clk_i     raw PS/2 clock line (asynchronous)
//   ps2_dat_i     raw PS/2 data line (asynchronous)
//   ps2_clk_oe_o  1 = pull PS/2 clock low
//   ps2_dat_oe_o  1 = pull PS/2 data low
//   tx_valid_i    byte to send is valid
//   tx_data_i     byte to send
//   tx_ready_o    core idle, accepts a byte
//   busy_o        transfer in progress
//   done_o        1-cycle pulse: transfer completed with ACK
//   ack_err_o     1-cycle pulse: ACK bit sampled high
//   timeout_o     1-cycle pulse: transfer aborted by timeout
// -----------------------------------------------------------------------------
module ps2_tx_core #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_WIDTH      = 18
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_WAIT_IDLE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] INHIBIT_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM  = CNT_WIDTH'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Line synchronizers
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_s;
  logic       dat_s;

  // NOTE: synchronizers reset to 1 (idle bus level) so leaving reset can
  // never look like a clock falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // ---------------------------------------------------------------------------
  // Optional stability filter: the filtered value only follows the
  // synchronized line once it has differed for 4 consecutive samples,
  // so pulses shorter than 4 clk_i cycles never reach the FSM.
  // ---------------------------------------------------------------------------
  logic clk_line;
  logic dat_line;

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       clk_f;
  logic       dat_f;
  logic [1:0] clk_run;
  logic [1:0] dat_run;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_f   <= 1'b1;
      dat_f   <= 1'b1;
      clk_run <= '0;
      dat_run <= '0;
    end else begin
      if (clk_s == clk_f) begin
        clk_run <= '0;
      end else if (clk_run == 2'd3) begin
        clk_f   <= clk_s;
        clk_run <= '0;
      end else begin
        clk_run <= clk_run + 2'd1;
      end

      if (dat_s == dat_f) begin
        dat_run <= '0;
      end else if (dat_run == 2'd3) begin
        dat_f   <= dat_s;
        dat_run <= '0;
      end else begin
        dat_run <= dat_run + 2'd1;
      end
    end
  end

  assign clk_line = clk_f;
  assign dat_line = dat_f;
`else
  assign clk_line = clk_s;
  assign dat_line = dat_s;
`endif

  // ---------------------------------------------------------------------------
  // Falling-edge detect on the (optionally filtered) clock line
  // ---------------------------------------------------------------------------
  logic clk_line_d;
  logic fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) clk_line_d <= 1'b1;
    else       clk_line_d <= clk_line;
  end

  assign fall = clk_line_d & ~clk_line;

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [3:0]           bitcnt;
  logic [7:0]           tx_byte;
  logic                 parity;
  logic                 ack_bit;
  logic                 timeout_hit;

  assign cnt_next = counter + CNT_WIDTH'(1);
  // A fall arriving in the same cycle as the limit wins over the timeout.
  assign timeout_hit = ~fall & (cnt_next == TIMEOUT_LIM);

  // NOTE: all state below uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      ps2_clk_oe_o <= 1'b0;
      ps2_dat_oe_o <= 1'b0;
      counter      <= '0;
      bitcnt       <= '0;
      tx_byte      <= '0;
      parity       <= 1'b0;
      ack_bit      <= 1'b0;
      done_o       <= 1'b0;
      ack_err_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      ack_err_o <= 1'b0;
      timeout_o <= 1'b0;

      case (state)
        S_IDLE: begin
          ps2_clk_oe_o <= 1'b0;
          ps2_dat_oe_o <= 1'b0;
          if (tx_valid_i) begin
            tx_byte      <= tx_data_i;
            parity       <= ~^tx_data_i;
            counter      <= '0;
            ps2_clk_oe_o <= 1'b1;
            state        <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (counter == INHIBIT_LAST) begin
            // Start bit: data low while clock is still held.
            ps2_dat_oe_o <= 1'b1;
            counter      <= '0;
            state        <= S_RTS;
          end else begin
            counter <= cnt_next;
          end
        end

        S_RTS: begin
          // Release clock; data stays low as the start bit.
          ps2_clk_oe_o <= 1'b0;
          bitcnt       <= '0;
          counter      <= '0;
          state        <= S_SHIFT;
        end

        S_SHIFT: begin
          if (fall) begin
            counter <= '0;
            bitcnt  <= bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              ps2_dat_oe_o <= ~tx_byte[bitcnt[2:0]];
            end else if (bitcnt == 4'd8) begin
              ps2_dat_oe_o <= ~parity;
            end else if (bitcnt == 4'd9) begin
              ps2_dat_oe_o <= 1'b0;
            end else begin
              ack_bit <= dat_line;
              state   <= S_WAIT_IDLE;
            end
          end else if (timeout_hit) begin
            ps2_clk_oe_o <= 1'b0;
            ps2_dat_oe_o <= 1'b0;
            counter      <= '0;
            timeout_o    <= 1'b1;
            state        <= S_IDLE;
          end else begin
            counter <= cnt_next;
          end
        end

        S_WAIT_IDLE: begin
          ps2_clk_oe_o <= 1'b0;
          ps2_dat_oe_o <= 1'b0;
          if (timeout_hit) begin
            counter   <= '0;
            timeout_o <= 1'b1;
            state     <= S_IDLE;
          end else if (clk_line && dat_line) begin
            counter   <= '0;
            done_o    <= ~ack_bit;
            ack_err_o <= ack_bit;
            state     <= S_IDLE;
          end else if (fall) begin
            counter <= '0;
          end else begin
            counter <= cnt_next;
          end
        end

        default: begin
          ps2_clk_oe_o <= 1'b0;
          ps2_dat_oe_o <= 1'b0;
          counter      <= '0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready_o = (state == S_IDLE);
  assign busy_o     = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_tx_core.sv
// -----------------------------------------------------------------------------
// tb_ps2_tx_core
//
// Directed bench for ps2_tx_core with a behavioural PS/2 device on
// open-drain lines. Device clock period is 40 clk_i cycles (20 low /
// 20 high) so consecutive falls stay inside TIMEOUT_CYCLES=64.
// -----------------------------------------------------------------------------
module tb_ps2_tx_core;

  localparam int INHIBIT  = 16;
  localparam int TIMEOUT  = 64;
  localparam int HALF     = 20;
`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int FALL_LAT = 7;
`else
  localparam int FALL_LAT = 3;
`endif

  logic       clk;
  logic       rst_i;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  logic dev_clk_low;
  logic dev_dat_low;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  int to_cnt = 0;
  int multi_cnt = 0;
  int to_cyc = 0;
  int last_fall_cyc = 0;
  logic ready_at_done = 1'b0;
  logic busy_after_done = 1'b0;
  logic prev_done = 1'b0;

  // Open-drain bus: low if either side pulls.
  assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_tx_core #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_WIDTH     (18)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ps2_clk_i   (ps2_clk),
    .ps2_dat_i   (ps2_dat),
    .ps2_clk_oe_o(ps2_clk_oe),
    .ps2_dat_oe_o(ps2_dat_oe),
    .tx_valid_i  (tx_valid),
    .tx_data_i   (tx_data),
    .tx_ready_o  (tx_ready),
    .busy_o      (busy),
    .done_o      (done),
    .ack_err_o   (ack_err),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      if (done)    done_cnt++;
      if (ack_err) ack_cnt++;
      if (timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if ((int'(done) + int'(ack_err) + int'(timeout)) > 1) multi_cnt++;
      if (prev_done) busy_after_done = busy;
      if (done) ready_at_done = tx_ready;
      prev_done = done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  // Device side of one frame: waits for RTS, produces nfalls clock pulses,
  // samples the line on each rising edge, optionally ACKs low on fall 10.
  // glitch_k >= 0 injects a 2-cycle low glitch in the high phase before fall glitch_k.
  task automatic dev_frame(input int nfalls, input bit ack_low, input int glitch_k,
                           output logic [9:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!(ps2_clk && !ps2_dat) && n < 400) begin
      step(1);
      n++;
    end
    if (n >= 400) begin
      check("rts_seen", 0, 1);
      return;
    end
    for (int k = 0; k < nfalls; k++) begin
      if (k == glitch_k) begin
        step(8);
        dev_clk_low = 1'b1;
        step(2);
        dev_clk_low = 1'b0;
        step(HALF - 10);
      end else begin
        step(HALF);
      end
      dev_clk_low = 1'b1;
      if (k == 10 && ack_low) dev_dat_low = 1'b1;
      last_fall_cyc = cyc;
      step(HALF);
      dev_clk_low = 1'b0;
      if (k < 10) bits[k] = ps2_dat;
    end
    if (nfalls == 11) begin
      step(2);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_pulse(input int budget);
    int start;
    int n;
    start = done_cnt + ack_cnt + to_cnt;
    n = 0;
    while ((done_cnt + ack_cnt + to_cnt) == start && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) check("pulse_seen", 0, 1);
  endtask

  initial begin
    logic [9:0] bits;
    logic [9:0] bits2;
    int n_inh;
    int n_rts;
    int d0, a0, t0;

    rst_i       = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    step(3);

    // Reset state
    check("rst_ready",   tx_ready,   1);
    check("rst_busy",    busy,       0);
    check("rst_clk_oe",  ps2_clk_oe, 0);
    check("rst_dat_oe",  ps2_dat_oe, 0);
    check("rst_pulses",  {done, ack_err, timeout}, 0);
    rst_i = 1'b0;
    step(2);

    // 0xED with ACK low: inhibit/RTS timing and frame contents
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    send_byte(8'hED);
    n_inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n_inh < 100) begin
      n_inh++;
      step(1);
    end
    n_rts = 0;
    while (ps2_clk_oe && ps2_dat_oe && n_rts < 100) begin
      n_rts++;
      step(1);
    end
    check("inhibit_len", n_inh, INHIBIT);
    check("rts_len",     n_rts, 1);
    dev_frame(11, 1'b1, -1, bits);
    wait_pulse(40);
    check("ed_frame",   bits, 10'h3ED);
    check("ed_done",    done_cnt - d0, 1);
    check("ed_ackerr",  ack_cnt - a0,  0);
    check("ed_timeout", to_cnt - t0,   0);
    check("ed_ready",   tx_ready, 1);
    step(5);

    // 0x00 with ACK high
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    send_byte(8'h00);
    dev_frame(11, 1'b0, -1, bits);
    wait_pulse(40);
    check("nack_frame",  bits, 10'h300);
    check("nack_ackerr", ack_cnt - a0,  1);
    check("nack_done",   done_cnt - d0, 0);
    step(5);

    // 0xFF, device stops after 4 bits
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    send_byte(8'hFF);
    dev_frame(4, 1'b0, -1, bits);
    wait_pulse(200);
    check("to_bits",    bits[3:0], 4'hF);
    check("to_pulse",   to_cnt - t0, 1);
    check("to_latency", to_cyc - last_fall_cyc, FALL_LAT + TIMEOUT);
    check("to_other",   (done_cnt - d0) + (ack_cnt - a0), 0);
    check("to_oe",      {ps2_clk_oe, ps2_dat_oe}, 0);
    check("to_ready",   tx_ready, 1);
    step(5);

    // Reset during bit 5 of 0x00
    send_byte(8'h00);
    dev_frame(5, 1'b0, -1, bits);
    step(HALF);
    dev_clk_low = 1'b1;
    step(6);
    check("pre_rst_dat_oe", ps2_dat_oe, 1);
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    rst_i = 1'b1;
    #1;
    check("rst_async_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    step(1);
    dev_clk_low = 1'b0;
    step(3);
    rst_i = 1'b0;
    step(100);
    check("rst_ready",  tx_ready, 1);
    check("rst_nopulse", (done_cnt - d0) + (ack_cnt - a0) + (to_cnt - t0), 0);

    // Back-to-back: 0xF4 then 0xAA with tx_valid held
    d0 = done_cnt;
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    step(1);
    check("b2b_busy", busy, 1);
    tx_data = 8'hAA;
    dev_frame(11, 1'b1, -1, bits);
    wait_pulse(40);
    check("b2b_ready_at_done", ready_at_done, 1);
    step(1);
    tx_valid = 1'b0;
    check("b2b_busy_after_done", busy_after_done, 1);
    dev_frame(11, 1'b1, -1, bits2);
    wait_pulse(40);
    check("b2b_frame1", bits,  10'h2F4);
    check("b2b_frame2", bits2, 10'h3AA);
    check("b2b_done",   done_cnt - d0, 2);
    check("b2b_ready",  tx_ready, 1);
    step(5);

`ifdef PS2_TX_GLITCH_FILTER_EN
    // 2-cycle clock glitch before fall 5 must be rejected
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    send_byte(8'hED);
    dev_frame(11, 1'b1, 5, bits);
    wait_pulse(40);
    check("glitch_frame", bits, 10'h3ED);
    check("glitch_done",  done_cnt - d0, 1);
    check("glitch_other", (ack_cnt - a0) + (to_cnt - t0), 0);
    step(5);
`endif

    check("pulse_exclusive", multi_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
